// File: rtl/regf_mem_arb_pkg.sv
// Shared types and constants for the regf memory-port arbiter.
package regf_mem_arb_pkg;

    localparam int unsigned SRSTCNT_W = 4;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, SRST} state_e;

endpackage

// File: rtl/regf_rr_arb.sv
// Combinational round-robin picker: first valid requester after rr_last, wrapping.
module regf_rr_arb
    import regf_mem_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDXW = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] rr_last,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] gnt_idx
);

    int unsigned idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        idx     = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = (32'(rr_last) + i) % NREQ;
            if (gnt == '0 && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = IDXW'(idx);
            end
        end
    end

endmodule

// File: rtl/regf_mem_arb.sv
// Round-robin arbiter sharing one regf memory port, with soft-reset sequencing.
module regf_mem_arb
    import regf_mem_arb_pkg::*;
#(
    parameter int unsigned NREQ        = 2,
    parameter int unsigned ADDRW       = 13,
    parameter int unsigned DATAW       = 32,
    parameter int unsigned SRST_CYCLES = 4
) (
    input  logic                   main_clk_i,
    input  logic                   main_rst_i,
    input  logic [NREQ-1:0]        req_valid_i,
    output logic [NREQ-1:0]        req_ready_o,
    input  logic [NREQ*ADDRW-1:0]  req_addr_i,
    input  logic [NREQ-1:0]        req_wena_i,
    input  logic [NREQ*DATAW-1:0]  req_wdata_i,
    output logic [NREQ-1:0]        resp_valid_o,
    output logic [DATAW-1:0]       resp_rdata_o,
    output logic                   resp_err_o,
    output logic                   mem_ena_o,
    output logic [ADDRW-1:0]       mem_addr_o,
    output logic                   mem_wena_o,
    output logic [DATAW-1:0]       mem_wdata_o,
    input  logic [DATAW-1:0]       mem_rdata_i,
    input  logic                   mem_err_i,
    input  logic                   soft_rst_req_i,
    output logic                   soft_rst_o,
    output logic                   busy_o
);

    localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e                 state_q, state_d;
    logic [IDXW-1:0]        rr_last_q, rr_last_d;
    logic                   srst_pend_q, srst_pend_d;
    logic [SRSTCNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDRW-1:0]       addr_q, addr_d;
    logic                   wena_q, wena_d;
    logic [DATAW-1:0]       wdata_q, wdata_d;
    logic [NREQ-1:0]        resp_valid_q, resp_valid_d;
    logic [DATAW-1:0]       resp_rdata_q, resp_rdata_d;
    logic                   resp_err_q, resp_err_d;

    logic [NREQ-1:0]        gnt;
    logic [IDXW-1:0]        gnt_idx;

    regf_rr_arb #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_arb (
        .req     (req_valid_i),
        .rr_last (rr_last_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            state_q      <= IDLE;
            rr_last_q    <= IDXW'(NREQ - 1);
            srst_pend_q  <= 1'b0;
            cnt_q        <= '0;
            addr_q       <= '0;
            wena_q       <= 1'b0;
            wdata_q      <= '0;
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_last_q    <= rr_last_d;
            srst_pend_q  <= srst_pend_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wena_q       <= wena_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_last_d    = rr_last_q;
        srst_pend_d  = srst_pend_q | soft_rst_req_i;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wena_d       = wena_q;
        wdata_d      = wdata_q;
        resp_valid_d = '0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        unique case (state_q)
            IDLE: begin
                // A pending soft reset is taken before any new grant.
                if (srst_pend_q) begin
                    state_d     = SRST;
                    srst_pend_d = 1'b0;
                    cnt_d       = SRSTCNT_W'(SRST_CYCLES - 1);
                end else if (|req_valid_i) begin
                    state_d   = ACCESS;
                    rr_last_d = gnt_idx;
                    addr_d    = req_addr_i[int'(gnt_idx)*ADDRW +: ADDRW];
                    wena_d    = req_wena_i[gnt_idx];
                    wdata_d   = req_wdata_i[int'(gnt_idx)*DATAW +: DATAW];
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                state_d                 = IDLE;
                resp_valid_d[rr_last_q] = 1'b1;
                resp_rdata_d            = wena_q ? '0 : mem_rdata_i;
                resp_err_d              = mem_err_i;
            end
            SRST: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        mem_ena_o   = 1'b0;
        soft_rst_o  = 1'b0;
        busy_o      = 1'b1;
        unique case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (!srst_pend_q && !main_rst_i) begin
                    req_ready_o = gnt;
                end
            end
            ACCESS:  mem_ena_o  = 1'b1;
            RESP:    ;
            SRST:    soft_rst_o = 1'b1;
            default: ;
        endcase
    end

    assign mem_addr_o   = addr_q;
    assign mem_wena_o   = wena_q & mem_ena_o;
    assign mem_wdata_o  = wdata_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;

endmodule
